// File: rtl/mpmc11_rd_burst_collect.sv
// Read-return burst collector: assembles one burst of read beats into a line and hands it off.
// Optional critical-word-first slot placement when MPMC11_RBC_CRIT_WORD_EN is defined.
module mpmc11_rd_burst_collect #(
  parameter int unsigned DW        = 128,
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned TW        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [7:0]                    burst_len,
  input  logic [TW-1:0]                 tag_i,
  input  logic [$clog2(MAX_BEATS)-1:0]  crit_beat,
  input  logic                          rd_valid,
  input  logic [DW-1:0]                 rd_data,
  output logic                          idle,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DW*MAX_BEATS-1:0]       out_data,
  output logic [TW-1:0]                 out_tag,
  output logic [7:0]                    out_beats,
  output logic                          err_stray,
  output logic                          err_clamp
);

  localparam int unsigned CW     = $clog2(MAX_BEATS);
  localparam int unsigned LW     = DW * MAX_BEATS;
  localparam logic [7:0]  MaxLen = 8'(MAX_BEATS - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  state_e        state_q;
  logic [7:0]    len_q, cnt_q;
  logic [TW-1:0] tag_q;
  logic [LW-1:0] line_q, line_wr;
  logic [7:0]    len_eff;
  logic [CW-1:0] idx;
  logic          beat_fire, line_done, out_free, load;

  assign len_eff   = (burst_len > MaxLen) ? MaxLen : burst_len;
  assign idle      = (state_q == StIdle);
  assign beat_fire = (state_q == StCollect) && rd_valid;
  assign line_done = beat_fire && (cnt_q == len_q);
  assign out_free  = !out_valid || out_ready;
  // A finished line moves to the output register either on its last beat or from HOLD.
  assign load      = out_free && (line_done || (state_q == StHold));

`ifdef MPMC11_RBC_CRIT_WORD_EN
  logic [7:0] crit_q, crit_mod, idx_sum, idx_full;
  logic       unused_idx;

  assign crit_mod = 8'(crit_beat) % (len_eff + 8'd1);
  assign idx_sum  = crit_q + cnt_q;
  // crit_q and cnt_q are both <= len_q, so a single subtraction performs the modulo.
  assign idx_full = (idx_sum > len_q) ? (idx_sum - len_q - 8'd1) : idx_sum;
  assign idx      = idx_full[CW-1:0];
  assign unused_idx = ^idx_full[7:CW];
`else
  logic unused_crit;

  assign idx         = cnt_q[CW-1:0];
  assign unused_crit = ^crit_beat;
`endif

  // Line contents including the beat arriving this cycle, so completion can forward it.
  always_comb begin
    line_wr = line_q;
    if (beat_fire) line_wr[idx*DW +: DW] = rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      cnt_q     <= '0;
      tag_q     <= '0;
      line_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_beats <= '0;
      err_stray <= 1'b0;
      err_clamp <= 1'b0;
`ifdef MPMC11_RBC_CRIT_WORD_EN
      crit_q    <= '0;
`endif
    end else begin
      err_stray <= rd_valid && (state_q != StCollect);
      err_clamp <= 1'b0;

      if (out_valid && out_ready) out_valid <= 1'b0;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= line_wr;
        out_tag   <= tag_q;
        out_beats <= len_q + 8'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StCollect;
            len_q     <= len_eff;
            tag_q     <= tag_i;
            cnt_q     <= '0;
            line_q    <= '0;
            err_clamp <= (burst_len > MaxLen);
`ifdef MPMC11_RBC_CRIT_WORD_EN
            crit_q    <= crit_mod;
`endif
          end
        end
        StCollect: begin
          if (beat_fire) begin
            line_q <= line_wr;
            if (line_done) begin
              state_q <= load ? StIdle : StHold;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StHold: begin
          if (load) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
